// File: rtl/fp_check_scoreboard_if.sv
// Handshake bundle between the reference-model / DUT side and the scoreboard.
// The master side offers expected entries and DUT results; the slave side
// (the scoreboard) answers with exp_ready.
interface fp_check_scoreboard_if #(
    parameter int XLEN  = 64,
    parameter int FLAGW = 5
) ();
    logic             exp_valid;
    logic             exp_ready;
    logic [XLEN-1:0]  exp_result;
    logic [FLAGW-1:0] exp_flags;
    logic [1:0]       exp_fmt;
    logic             exp_nanchk;
    logic             exp_last;
    logic             dut_valid;
    logic [XLEN-1:0]  dut_result;
    logic [FLAGW-1:0] dut_flags;

    modport master (
        output exp_valid, exp_result, exp_flags, exp_fmt, exp_nanchk, exp_last,
        output dut_valid, dut_result, dut_flags,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_result, exp_flags, exp_fmt, exp_nanchk, exp_last,
        input  dut_valid, dut_result, dut_flags,
        output exp_ready
    );
endinterface

// File: rtl/fp_check_scoreboard.sv
// Expected-result scoreboard for fp_unit verification. Reference results are
// queued in a FIFO and popped one per DUT result pulse, so any DUT latency and
// back-to-back issue are tolerated. Canonical-NaN results are compared only on
// the exponent/quiet bits when masking is requested for the entry.
module fp_check_scoreboard #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 64,
    parameter int FLAGW = 5,
    parameter int CNTW  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    fp_check_scoreboard_if.slave     bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNTW-1:0]          chk_count,
    output logic [CNTW-1:0]          err_count,
    output logic                     spurious,
    output logic                     fail,
    output logic                     done,
    output logic                     pass,
    output logic [XLEN-1:0]          ff_result_diff,
    output logic [FLAGW-1:0]         ff_flags_diff,
    output logic [XLEN-1:0]          ff_exp,
    output logic [XLEN-1:0]          ff_dut
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [XLEN-1:0]  r_memResult [DEPTH];
    logic [FLAGW-1:0] r_memFlags  [DEPTH];
    logic [1:0]       r_memFmt    [DEPTH];
    logic             r_memNanchk [DEPTH];
    logic             r_memLast   [DEPTH];

    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_level;
    logic [CNTW-1:0]  r_chkCount;
    logic [CNTW-1:0]  r_errCount;
    logic             r_spurious;
    logic             r_fail;
    logic             r_done;
    logic             r_pass;
    logic [XLEN-1:0]  r_ffResultDiff;
    logic [FLAGW-1:0] r_ffFlagsDiff;
    logic [XLEN-1:0]  r_ffExp;
    logic [XLEN-1:0]  r_ffDut;

    logic             w_push;
    logic             w_pop;
    logic             w_spur;
    logic             w_error;
    logic             w_mismatch;
    logic             w_doneNext;
    logic             w_failNext;
    logic [XLEN-1:0]  w_headResult;
    logic [FLAGW-1:0] w_headFlags;
    logic [1:0]       w_headFmt;
    logic             w_headNanchk;
    logic             w_headLast;
    logic [XLEN-1:0]  w_rdiff;
    logic [FLAGW-1:0] w_fdiff;

    assign bus.exp_ready = (r_level != LVL_FULL);
    assign w_push        = bus.exp_valid & bus.exp_ready;
    // A result is only consumed when an entry is already queued and the run has
    // not ended; anything else is a result nobody asked for.
    assign w_pop         = bus.dut_valid & (r_level != '0) & ~r_done;
    assign w_spur        = bus.dut_valid & ~w_pop;

    assign w_headResult  = r_memResult[r_rdPtr];
    assign w_headFlags   = r_memFlags[r_rdPtr];
    assign w_headFmt     = r_memFmt[r_rdPtr];
    assign w_headNanchk  = r_memNanchk[r_rdPtr];
    assign w_headLast    = r_memLast[r_rdPtr];

    // Result/flag difference; a canonical NaN from the DUT only has to agree
    // with the reference on exponent and quiet bit, since payload is free.
    always_comb begin
        w_rdiff = bus.dut_result ^ w_headResult;
        if (w_headNanchk) begin
            if (w_headFmt == 2'd0) begin
                if (bus.dut_result[31:0] == 32'h7FC00000) begin
                    w_rdiff        = '0;
                    w_rdiff[30:22] = bus.dut_result[30:22] ^ w_headResult[30:22];
                end
            end else if (bus.dut_result == XLEN'(64'h7FF8000000000000)) begin
                w_rdiff        = '0;
                w_rdiff[62:51] = bus.dut_result[62:51] ^ w_headResult[62:51];
            end
        end
    end

    assign w_fdiff    = bus.dut_flags ^ w_headFlags;
    assign w_mismatch = (w_rdiff != '0) | (w_fdiff != '0);
    assign w_error    = (w_pop & w_mismatch) | w_spur;
    assign w_doneNext = r_done | (w_pop & w_headLast);
    assign w_failNext = r_fail | w_error;

    // Entry storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_memResult[r_wrPtr] <= bus.exp_result;
            r_memFlags[r_wrPtr]  <= bus.exp_flags;
            r_memFmt[r_wrPtr]    <= bus.exp_fmt;
            r_memNanchk[r_wrPtr] <= bus.exp_nanchk;
            r_memLast[r_wrPtr]   <= bus.exp_last;
        end
    end

    // Pointers, occupancy, saturating counters, sticky status and first-failure capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr        <= '0;
            r_rdPtr        <= '0;
            r_level        <= '0;
            r_chkCount     <= '0;
            r_errCount     <= '0;
            r_spurious     <= 1'b0;
            r_fail         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_ffResultDiff <= '0;
            r_ffFlagsDiff  <= '0;
            r_ffExp        <= '0;
            r_ffDut        <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
            if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
            else if (w_pop && !w_push) r_level <= r_level - (AW+1)'(1);
            if (w_pop && (r_chkCount != '1))   r_chkCount <= r_chkCount + CNTW'(1);
            if (w_error && (r_errCount != '1)) r_errCount <= r_errCount + CNTW'(1);
            if (w_spur) r_spurious <= 1'b1;
            r_fail <= w_failNext;
            r_done <= w_doneNext;
            r_pass <= w_doneNext & ~w_failNext;
            if (w_error && !r_fail) begin
                if (w_spur) begin
                    r_ffResultDiff <= '0;
                    r_ffFlagsDiff  <= '0;
                    r_ffExp        <= '0;
                end else begin
                    r_ffResultDiff <= w_rdiff;
                    r_ffFlagsDiff  <= w_fdiff;
                    r_ffExp        <= w_headResult;
                end
                r_ffDut <= bus.dut_result;
            end
        end
    end

    assign level          = r_level;
    assign chk_count      = r_chkCount;
    assign err_count      = r_errCount;
    assign spurious       = r_spurious;
    assign fail           = r_fail;
    assign done           = r_done;
    assign pass           = r_pass;
    assign ff_result_diff = r_ffResultDiff;
    assign ff_flags_diff  = r_ffFlagsDiff;
    assign ff_exp         = r_ffExp;
    assign ff_dut         = r_ffDut;
endmodule

// File: tb/tb_fp_check_scoreboard.sv
// Directed bench for fp_check_scoreboard: compare-rule vector table plus
// hand-written sequences for FIFO full/wrap, spurious results and reset.
module tb_fp_check_scoreboard;
    logic        clock;
    logic        reset;
    logic [4:0]  level;
    logic [31:0] chk_count;
    logic [31:0] err_count;
    logic        spurious;
    logic        fail;
    logic        done;
    logic        pass;
    logic [63:0] ff_result_diff;
    logic [4:0]  ff_flags_diff;
    logic [63:0] ff_exp;
    logic [63:0] ff_dut;

    int checkCount = 0;
    int failCount  = 0;

    fp_check_scoreboard_if #(.XLEN(64), .FLAGW(5)) bus ();

    fp_check_scoreboard #(.DEPTH(16), .XLEN(64), .FLAGW(5), .CNTW(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .level          (level),
        .chk_count      (chk_count),
        .err_count      (err_count),
        .spurious       (spurious),
        .fail           (fail),
        .done           (done),
        .pass           (pass),
        .ff_result_diff (ff_result_diff),
        .ff_flags_diff  (ff_flags_diff),
        .ff_exp         (ff_exp),
        .ff_dut         (ff_dut)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] expResult;
        logic [4:0]  expFlags;
        logic [1:0]  fmt;
        logic        nanchk;
        logic [63:0] dutResult;
        logic [4:0]  dutFlags;
        logic        mismatch;
    } vec_t;

    vec_t vecs [11];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one clock cycle of push and/or DUT result, then sample 1 unit after the edge.
    task automatic applyStimulus(input logic doPush, input logic [63:0] res, input logic [4:0] flags,
                                 input logic [1:0] fmt, input logic nanchk, input logic last,
                                 input logic doPop, input logic [63:0] dres, input logic [4:0] dflags);
        bus.exp_valid  = doPush;
        bus.exp_result = res;
        bus.exp_flags  = flags;
        bus.exp_fmt    = fmt;
        bus.exp_nanchk = nanchk;
        bus.exp_last   = last;
        bus.dut_valid  = doPop;
        bus.dut_result = dres;
        bus.dut_flags  = dflags;
        @(posedge clock);
        #1;
        bus.exp_valid  = 1'b0;
        bus.dut_valid  = 1'b0;
    endtask

    task automatic pushEntry(input logic [63:0] res, input logic [4:0] flags, input logic [1:0] fmt,
                             input logic nanchk, input logic last);
        applyStimulus(1'b1, res, flags, fmt, nanchk, last, 1'b0, 64'h0, 5'h0);
    endtask

    task automatic popEntry(input logic [63:0] dres, input logic [4:0] dflags);
        applyStimulus(1'b0, 64'h0, 5'h0, 2'd0, 1'b0, 1'b0, 1'b1, dres, dflags);
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_level"},     64'(level), 64'd0);
        checkOutput({tag, "_ready"},     64'(bus.exp_ready), 64'd1);
        checkOutput({tag, "_chk"},       64'(chk_count), 64'd0);
        checkOutput({tag, "_err"},       64'(err_count), 64'd0);
        checkOutput({tag, "_spurious"},  64'(spurious), 64'd0);
        checkOutput({tag, "_fail"},      64'(fail), 64'd0);
        checkOutput({tag, "_done"},      64'(done), 64'd0);
        checkOutput({tag, "_pass"},      64'(pass), 64'd0);
        checkOutput({tag, "_ffrdiff"},   ff_result_diff, 64'd0);
        checkOutput({tag, "_fffdiff"},   64'(ff_flags_diff), 64'd0);
        checkOutput({tag, "_ffexp"},     ff_exp, 64'd0);
        checkOutput({tag, "_ffdut"},     ff_dut, 64'd0);
    endtask

    // Main directed sequence.
    initial begin
        int expChk;
        int expErr;

        vecs[0]  = '{64'h000000007FC00001, 5'h00, 2'd0, 1'b1, 64'h000000007FC00000, 5'h00, 1'b0};
        vecs[1]  = '{64'h000000007FC00001, 5'h00, 2'd0, 1'b0, 64'h000000007FC00000, 5'h00, 1'b1};
        vecs[2]  = '{64'h7FF8000000000001, 5'h00, 2'd1, 1'b1, 64'h7FF8000000000000, 5'h00, 1'b0};
        vecs[3]  = '{64'hFFF8000000000000, 5'h00, 2'd1, 1'b1, 64'h7FF8000000000000, 5'h00, 1'b0};
        vecs[4]  = '{64'h7FF0000000000000, 5'h00, 2'd1, 1'b1, 64'h7FF8000000000000, 5'h00, 1'b1};
        vecs[5]  = '{64'h000000007F800000, 5'h00, 2'd0, 1'b1, 64'h000000007FC00000, 5'h00, 1'b1};
        vecs[6]  = '{64'h000000003F800000, 5'h00, 2'd0, 1'b1, 64'h000000003F800001, 5'h00, 1'b1};
        vecs[7]  = '{64'h3FF0000000000000, 5'h01, 2'd2, 1'b1, 64'h3FF0000000000000, 5'h01, 1'b0};
        vecs[8]  = '{64'hFFFFFFFF7FC00000, 5'h00, 2'd0, 1'b1, 64'h000000007FC00000, 5'h00, 1'b0};
        vecs[9]  = '{64'h7FF8000000000001, 5'h00, 2'd1, 1'b0, 64'h7FF8000000000000, 5'h00, 1'b1};
        vecs[10] = '{64'h0000000040000000, 5'h10, 2'd0, 1'b0, 64'h0000000040000000, 5'h00, 1'b1};

        reset = 1'b1;
        bus.exp_valid = 1'b0;
        bus.dut_valid = 1'b0;
        bus.exp_result = '0;
        bus.exp_flags = '0;
        bus.exp_fmt = '0;
        bus.exp_nanchk = 1'b0;
        bus.exp_last = 1'b0;
        bus.dut_result = '0;
        bus.dut_flags = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checkResetState("rst");

        // Three matching single-precision results, the third marks the end of the run.
        pushEntry(64'h3F800000, 5'h0, 2'd0, 1'b1, 1'b0);
        pushEntry(64'h3F800000, 5'h0, 2'd0, 1'b1, 1'b0);
        pushEntry(64'h3F800000, 5'h0, 2'd0, 1'b1, 1'b1);
        checkOutput("basic_level3", 64'(level), 64'd3);
        for (int i = 0; i < 3; i++) popEntry(64'h3F800000, 5'h0);
        checkOutput("basic_chk", 64'(chk_count), 64'd3);
        checkOutput("basic_err", 64'(err_count), 64'd0);
        checkOutput("basic_done", 64'(done), 64'd1);
        checkOutput("basic_pass", 64'(pass), 64'd1);
        checkOutput("basic_level0", 64'(level), 64'd0);
        // A result after the last vector is spurious.
        popEntry(64'h3F800000, 5'h0);
        checkOutput("postdone_spur", 64'(spurious), 64'd1);
        checkOutput("postdone_err", 64'(err_count), 64'd1);
        checkOutput("postdone_chk", 64'(chk_count), 64'd3);
        checkOutput("postdone_pass", 64'(pass), 64'd0);
        checkOutput("postdone_done", 64'(done), 64'd1);

        // Compare-rule table.
        doReset();
        expChk = 0;
        expErr = 0;
        for (int i = 0; i < 11; i++) begin
            pushEntry(vecs[i].expResult, vecs[i].expFlags, vecs[i].fmt, vecs[i].nanchk, 1'b0);
            popEntry(vecs[i].dutResult, vecs[i].dutFlags);
            expChk++;
            if (vecs[i].mismatch) expErr++;
            checkOutput($sformatf("vec%0d_err", i), 64'(err_count), 64'(expErr));
            checkOutput($sformatf("vec%0d_chk", i), 64'(chk_count), 64'(expChk));
        end
        checkOutput("vec_ffrdiff", ff_result_diff, 64'h1);
        checkOutput("vec_fffdiff", 64'(ff_flags_diff), 64'h0);
        checkOutput("vec_ffexp", ff_exp, 64'h7FC00001);
        checkOutput("vec_ffdut", ff_dut, 64'h7FC00000);
        checkOutput("vec_fail", 64'(fail), 64'd1);
        checkOutput("vec_spur", 64'(spurious), 64'd0);

        // Flags-only mismatch on the final double-precision vector.
        doReset();
        pushEntry(64'h3FF0000000000000, 5'h01, 2'd1, 1'b1, 1'b1);
        popEntry(64'h3FF0000000000000, 5'h00);
        checkOutput("flag_fffdiff", 64'(ff_flags_diff), 64'h01);
        checkOutput("flag_ffrdiff", ff_result_diff, 64'h0);
        checkOutput("flag_ffexp", ff_exp, 64'h3FF0000000000000);
        checkOutput("flag_err", 64'(err_count), 64'd1);
        checkOutput("flag_done", 64'(done), 64'd1);
        checkOutput("flag_pass", 64'(pass), 64'd0);

        // Fill, overflow attempt, pop at full with a same-cycle push, then pointer wrap.
        doReset();
        for (int i = 0; i < 16; i++) pushEntry(64'(i), 5'h0, 2'd1, 1'b0, 1'b0);
        checkOutput("full_level", 64'(level), 64'd16);
        checkOutput("full_ready", 64'(bus.exp_ready), 64'd0);
        pushEntry(64'hDEAD, 5'h0, 2'd1, 1'b0, 1'b0);
        checkOutput("full_drop_level", 64'(level), 64'd16);
        applyStimulus(1'b1, 64'hBEEF, 5'h0, 2'd1, 1'b0, 1'b0, 1'b1, 64'd0, 5'h0);
        checkOutput("full_pop_level", 64'(level), 64'd15);
        checkOutput("full_pop_ready", 64'(bus.exp_ready), 64'd1);
        for (int i = 1; i < 16; i++) popEntry(64'(i), 5'h0);
        checkOutput("drain_level", 64'(level), 64'd0);
        checkOutput("drain_err", 64'(err_count), 64'd0);
        pushEntry(64'd1000, 5'h0, 2'd1, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++)
            applyStimulus(1'b1, 64'(1001 + k), 5'h0, 2'd1, 1'b0, 1'b0, 1'b1, 64'(1000 + k), 5'h0);
        checkOutput("wrap_level1", 64'(level), 64'd1);
        popEntry(64'd1040, 5'h0);
        checkOutput("wrap_err", 64'(err_count), 64'd0);
        checkOutput("wrap_chk", 64'(chk_count), 64'd57);
        checkOutput("wrap_level0", 64'(level), 64'd0);

        // Result with an empty FIFO while an entry arrives in the same cycle.
        doReset();
        applyStimulus(1'b1, 64'h3F800000, 5'h0, 2'd0, 1'b1, 1'b0, 1'b1, 64'h12345678, 5'h3);
        checkOutput("spur_flag", 64'(spurious), 64'd1);
        checkOutput("spur_err", 64'(err_count), 64'd1);
        checkOutput("spur_chk", 64'(chk_count), 64'd0);
        checkOutput("spur_level", 64'(level), 64'd1);
        checkOutput("spur_fail", 64'(fail), 64'd1);
        checkOutput("spur_ffdut", ff_dut, 64'h12345678);
        checkOutput("spur_ffexp", ff_exp, 64'h0);

        // Reset in the middle of a failing run, then a clean two-vector run.
        for (int i = 0; i < 4; i++) pushEntry(64'h55, 5'h0, 2'd1, 1'b0, 1'b0);
        checkOutput("mid_level5", 64'(level), 64'd5);
        doReset();
        checkResetState("midrst");
        pushEntry(64'h40490FDB, 5'h01, 2'd0, 1'b1, 1'b0);
        pushEntry(64'h400921FB54442D18, 5'h00, 2'd1, 1'b1, 1'b1);
        popEntry(64'h40490FDB, 5'h01);
        popEntry(64'h400921FB54442D18, 5'h00);
        checkOutput("clean_chk", 64'(chk_count), 64'd2);
        checkOutput("clean_err", 64'(err_count), 64'd0);
        checkOutput("clean_pass", 64'(pass), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule

// File: doc/fp_check_scoreboard.md
Name: fp_check_scoreboard

Overview:
- Synthesisable expected-result scoreboard for fp_unit verification.
- Buffers reference results, with their flags, format and compare mode, in a parametrised FIFO.
- Pops one entry per DUT `ready` pulse and compares it against the DUT output.
- Applies RISC-V canonical-NaN masking, counts checks and errors, captures the first mismatch, and signals pass/fail/done.
- Replaces the fixed same-cycle compare with one that tolerates any DUT latency and back-to-back issue.

Parameters:
- DEPTH, 16, expected-FIFO entries; power of two, ≥2.
- XLEN, 64, result width.
- FLAGW, 5, exception flag width (NV,DZ,OF,UF,NX).
- CNTW, 32, width of check and error counters.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- exp_valid  in  1  expected entry offered.
- exp_ready  out  1  FIFO can accept; high when count<DEPTH.
- exp_result  in  XLEN  reference result.
- exp_flags  in  FLAGW  reference flags.
- exp_fmt  in  2  0=single, any other value=double.
- exp_nanchk  in  1  1=apply canonical-NaN masking (arithmetic ops); 0=exact compare (fcmp, fcvt_f2i).
- exp_last  in  1  marks final vector of the run.
- dut_valid  in  1  DUT result ready pulse.
- dut_result  in  XLEN  DUT result.
- dut_flags  in  FLAGW  DUT flags.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- chk_count  out  CNTW  compares performed.
- err_count  out  CNTW  mismatches plus spurious results.
- spurious  out  1  sticky; dut_valid seen with FIFO empty.
- fail  out  1  sticky; any error.
- done  out  1  sticky; exp_last entry checked.
- pass  out  1  done & ~fail.
- ff_result_diff  out  XLEN  first-failure result diff.
- ff_flags_diff  out  FLAGW  first-failure flags diff.
- ff_exp  out  XLEN  first-failure expected result.
- ff_dut  out  XLEN  first-failure DUT result.

Behaviour:
- Reset (synchronous, active-high): every output, counter, sticky bit, FIFO pointer and first-failure register clears to 0.
  - exp_ready is 1 in the first cycle after reset.
  - Reset mid-run discards all FIFO contents.
- Push: on exp_valid & exp_ready, write {result,flags,fmt,nanchk,last} at the write pointer.
  - Pointers wrap modulo DEPTH.
  - When full, exp_ready=0 and exp_valid is ignored (no overwrite).
- Pop: on dut_valid with level>0, read the head and advance the read pointer.
  - No bypass: dut_valid while level==0 counts as spurious even if a push occurs in the same cycle.
  - Spurious event sets spurious and fail and increments err_count; chk_count is unchanged.
- Simultaneous push and pop at non-empty, non-full: level unchanged.
  - At full: the pop frees a slot, but exp_ready was 0 that cycle, so no push.
- Compare (combinational on head vs DUT):
  - fmt==0, nanchk=1, dut[31:0]==32'h7FC00000: rdiff = {32'h0, 1'b0, dut[30:22]^exp[30:22], 22'h0}.
  - fmt!=0, nanchk=1, dut==64'h7FF8000000000000: rdiff = {1'b0, dut[62:51]^exp[62:51], 51'h0}.
  - Otherwise: rdiff = dut ^ exp (full XLEN).
  - fdiff = dut_flags ^ exp_flags.
  - mismatch = (rdiff!=0) | (fdiff!=0).
- Result latency: counters, sticky bits and ff_* update on the clock edge that pops. Values are visible in the cycle after dut_valid.
  - chk_count increments on every pop.
  - err_count increments on every mismatch.
  - The first error of any kind (mismatch or spurious) loads ff_* exactly once, while fail was 0. A spurious first error loads ff_dut=dut_result and the other ff_* fields with 0.
- Counters saturate at all-ones; they do not wrap.
- done: set when the popped entry has last=1. After done, further dut_valid pulses are spurious.
  - pass = done & ~fail, registered.
  - done remains set until reset.
- level counts 0..DEPTH inclusive.

Test Plan:
- Reset, then push 3 single entries (exp_result=0x3F800000, flags=0) and return 3 matching dut_valid pulses; mark the 3rd exp_last -> chk_count=3, err_count=0, done=1, pass=1, level=0.
- Push fmt=0, nanchk=1, exp=0x7FC00001; DUT returns 0x7FC00000 -> rdiff=0, no error. Repeat with nanchk=0 -> err_count=1, fail=1, ff_result_diff=0x1.
- Push fmt=1, exp=0x3FF0000000000000, flags=0x01; DUT returns the same result with flags=0x00 -> ff_flags_diff=0x01, ff_exp=0x3FF0000000000000, err_count=1, pass=0 after last.
- Push DEPTH=16 entries without a pop -> level=16, exp_ready=0; a 17th exp_valid is dropped. One pop -> level=15 and exp_ready=1 next cycle. Walk 40 push/pop pairs to exercise pointer wrap with zero errors.
- dut_valid with an empty FIFO and a same-cycle push -> spurious=1, err_count=1, chk_count=0, level=1.
- Assert reset mid-run with level=5 and fail=1 -> all outputs 0, exp_ready=1; a subsequent clean 2-vector run ends with pass=1.
